// File: rtl/ramb16_s36_arb2.sv
// Two-requester round-robin front end for one 512x36 single-port block RAM.
// Define RAMB16_ARB2_LOCK_EN to add bounded per-requester lock ownership.
module ramb16_s36_arb2 #(
    parameter int          LOCK_MAX = 16,
    parameter logic [35:0] SRVAL    = 36'h0
) (
    input  logic        clk,
    input  logic        ssr,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [8:0]  a_addr,
    input  logic [31:0] a_di,
    input  logic [3:0]  a_dip,
`ifdef RAMB16_ARB2_LOCK_EN
    input  logic        a_lock,
    input  logic        b_lock,
`endif
    input  logic        b_req,
    input  logic        b_we,
    input  logic [8:0]  b_addr,
    input  logic [31:0] b_di,
    input  logic [3:0]  b_dip,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] rdo,
    output logic [3:0]  rdop,
    output logic        ram_en,
    output logic        ram_we,
    output logic        ram_ssr,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_di,
    output logic [3:0]  ram_dip,
    input  logic [31:0] ram_do,
    input  logic [3:0]  ram_dop
);

    logic        last_b;
    logic        tie_a;
    logic        tie_b;
    logic        pick_a;
    logic        pick_b;
    logic        rv_a;
    logic        rv_b;
    logic [35:0] hold;

    // Round-robin: on a tie the requester that did not win last goes.
    always_comb begin
        tie_a = 1'b0;
        tie_b = 1'b0;
        if (a_req && b_req) begin
            tie_a = last_b;
            tie_b = ~last_b;
        end else begin
            tie_a = a_req;
            tie_b = b_req;
        end
    end

`ifdef RAMB16_ARB2_LOCK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [5:0] CNT_TOP = 6'(LOCK_MAX - 1);

    state_t     state;
    logic [5:0] cnt;
    logic [5:0] cnt_nxt;

    assign cnt_nxt = cnt + 6'd1;

    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        unique case (state)
            IDLE: begin
                pick_a = tie_a;
                pick_b = tie_b;
            end
            OWN_A:   pick_a = a_req;
            OWN_B:   pick_b = b_req;
            default: ;
        endcase
    end

    // Owner keeps the RAM until it drops lock or hits the cycle cap.
    always_ff @(posedge clk) begin
        if (ssr) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= 6'd0;
                    if (a_gnt && a_lock)
                        state <= OWN_A;
                    else if (b_gnt && b_lock)
                        state <= OWN_B;
                end
                OWN_A: begin
                    if (!a_lock || cnt_nxt == CNT_TOP) begin
                        state <= IDLE;
                        cnt   <= 6'd0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                OWN_B: begin
                    if (!b_lock || cnt_nxt == CNT_TOP) begin
                        state <= IDLE;
                        cnt   <= 6'd0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end
`else
    assign pick_a = tie_a;
    assign pick_b = tie_b;
`endif

    assign a_gnt   = pick_a & ~ssr;
    assign b_gnt   = pick_b & ~ssr;
    assign ram_ssr = ssr;
    assign ram_en  = a_gnt | b_gnt;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = a_addr;
        ram_di   = a_di;
        ram_dip  = a_dip;
        if (a_gnt) begin
            ram_we = a_we;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_di   = b_di;
            ram_dip  = b_dip;
        end
    end

    // Within a lock only the owner is granted, so LAST already names it
    // when the lock ends.
    always_ff @(posedge clk) begin
        if (ssr)
            last_b <= 1'b1;
        else if (a_gnt)
            last_b <= 1'b0;
        else if (b_gnt)
            last_b <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (ssr) begin
            rv_a <= 1'b0;
            rv_b <= 1'b0;
            hold <= SRVAL;
        end else begin
            rv_a <= a_gnt & ~a_we;
            rv_b <= b_gnt & ~b_we;
            if (rv_a || rv_b)
                hold <= {ram_dop, ram_do};
        end
    end

    assign a_rvalid      = rv_a;
    assign b_rvalid      = rv_b;
    assign {rdop, rdo}   = (rv_a || rv_b) ? {ram_dop, ram_do} : hold;

endmodule

// File: tb/tb_ramb16_s36_arb2.sv
// Randomized and directed bench for ramb16_s36_arb2 against a
// transaction-level model plus a behavioural 512x36 RAM.
module tb_ramb16_s36_arb2;

    localparam int          LMAX = 4;
    localparam logic [35:0] SRV  = 36'h9_1234_5678;

    logic        clk = 1'b0;
    logic        ssr = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic        a_we = 1'b0, b_we = 1'b0;
    logic        a_lock = 1'b0, b_lock = 1'b0;
    logic [8:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_di = '0, b_di = '0;
    logic [3:0]  a_dip = '0, b_dip = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] rdo;
    logic [3:0]  rdop;
    logic        ram_en, ram_we, ram_ssr;
    logic [8:0]  ram_addr;
    logic [31:0] ram_di;
    logic [3:0]  ram_dip;
    logic [31:0] ram_do;
    logic [3:0]  ram_dop;

    always #5 clk = ~clk;

    ramb16_s36_arb2 #(.LOCK_MAX(LMAX), .SRVAL(SRV)) dut (
        .clk(clk), .ssr(ssr),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .a_di(a_di), .a_dip(a_dip),
`ifdef RAMB16_ARB2_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .b_di(b_di), .b_dip(b_dip),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdo(rdo), .rdop(rdop),
        .ram_en(ram_en), .ram_we(ram_we), .ram_ssr(ram_ssr),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_dip(ram_dip),
        .ram_do(ram_do), .ram_dop(ram_dop)
    );

    logic [35:0] ram_mem [512];

    always @(posedge clk) begin
        if (ram_ssr) begin
            {ram_dop, ram_do} <= SRV;
        end else if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= {ram_dip, ram_di};
                {ram_dop, ram_do} <= {ram_dip, ram_di};
            end else begin
                {ram_dop, ram_do} <= ram_mem[ram_addr];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner 0=none 1=A 2=B; held counts cycles spent owned.
    bit          m_ok = 1'b0;
    bit          m_last_b = 1'b1;
    bit          m_pa = 1'b0, m_pb = 1'b0;
    logic [35:0] m_pdata = '0;
    logic [35:0] m_hold = '0;
    logic [35:0] ref_mem [512];
    int          m_owner = 0;
    int          m_held = 0;

    bit          o_ag, o_bg, o_av, o_bv;
    logic [8:0]  o_addr;
    logic [35:0] o_rd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit          ea, eb, ew;
        logic [8:0]  ead;
        logic [35:0] ed;
        @(negedge clk);
        ea = 1'b0;
        eb = 1'b0;
        if (!ssr) begin
            if (m_owner == 1) begin
                ea = a_req;
            end else if (m_owner == 2) begin
                eb = b_req;
            end else if (a_req && b_req) begin
                ea = m_last_b;
                eb = !m_last_b;
            end else begin
                ea = a_req;
                eb = b_req;
            end
        end
        ew  = ea ? a_we : (eb ? b_we : 1'b0);
        ead = ea ? a_addr : b_addr;
        ed  = ea ? {a_dip, a_di} : {b_dip, b_di};
        chk("a_gnt", a_gnt, ea);
        chk("b_gnt", b_gnt, eb);
        chk("ram_en", ram_en, ea | eb);
        chk("ram_we", ram_we, ew);
        chk("ram_ssr", ram_ssr, ssr);
        if (ea || eb)
            chk("ram_addr", ram_addr, ead);
        if (ew)
            chk("ram_wdata", {ram_dip, ram_di}, ed);
        if (m_ok) begin
            chk("a_rvalid", a_rvalid, m_pa);
            chk("b_rvalid", b_rvalid, m_pb);
            chk("rdata", {rdop, rdo}, (m_pa || m_pb) ? m_pdata : m_hold);
        end
        o_ag   = a_gnt;
        o_bg   = b_gnt;
        o_av   = a_rvalid;
        o_bv   = b_rvalid;
        o_addr = ram_addr;
        o_rd   = {rdop, rdo};
        @(posedge clk);
        if (ssr) begin
            m_ok     = 1'b1;
            m_last_b = 1'b1;
            m_pa     = 1'b0;
            m_pb     = 1'b0;
            m_hold   = SRV;
            m_owner  = 0;
            m_held   = 0;
        end else begin
            if (m_pa || m_pb)
                m_hold = m_pdata;
            m_pa = ea && !a_we;
            m_pb = eb && !b_we;
            if (m_pa || m_pb)
                m_pdata = ref_mem[ead];
            if (ew)
                ref_mem[ead] = ed;
            if (ea) m_last_b = 1'b0;
            if (eb) m_last_b = 1'b1;
            if (m_owner != 0) begin
                m_held++;
                if (!(m_owner == 1 ? a_lock : b_lock) || m_held >= LMAX - 1) begin
                    m_owner = 0;
                    m_held  = 0;
                end
            end else if (ea && a_lock) begin
                m_owner = 1;
            end else if (eb && b_lock) begin
                m_owner = 2;
            end
        end
        #1;
    endtask

    task automatic idle_all();
        a_req  = 1'b0;
        b_req  = 1'b0;
        a_lock = 1'b0;
        b_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        ssr = 1'b1;
        step();
        ssr = 1'b0;
    endtask

    initial begin
        int ca, cb;
        do_reset();
        do_reset();
        step();
        chk("rst_rdata", o_rd, SRV);
        chk("rst_rvalid", {o_av, o_bv}, 2'b00);

        // Fill the RAM through port A so every word is known.
        for (int i = 0; i < 512; i++) begin
            a_req  = 1'b1;
            a_we   = 1'b1;
            a_addr = 9'(i);
            a_di   = $urandom;
            a_dip  = 4'($urandom);
            step();
        end
        idle_all();
        a_we = 1'b0;
        step();

        // First tie after reset goes to A, then B.
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        a_we = 1'b0;  b_we = 1'b0;
        a_addr = 9'h005; b_addr = 9'h1FF;
        step();
        chk("tie0_a", o_ag, 1'b1);
        chk("tie0_addr", o_addr, 9'h005);
        step();
        chk("tie1_b", o_bg, 1'b1);
        chk("tie1_addr", o_addr, 9'h1FF);
        chk("tie1_arv", o_av, 1'b1);
        idle_all();
        step();
        chk("tie2_brv", o_bv, 1'b1);

        // Write then read back through the other port.
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'h010;
        a_di = 32'hDEADBEEF; a_dip = 4'hA;
        step();
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 9'h010;
        step();
        chk("wr_no_rv", o_av, 1'b0);
        chk("rd_b_gnt", o_bg, 1'b1);
        b_req = 1'b0;
        step();
        chk("rd_b_rv", o_bv, 1'b1);
        chk("rd_b_data", o_rd, {4'hA, 32'hDEADBEEF});

        // Ten cycles of contention alternate strictly.
        ca = 0; cb = 0;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("alt", {o_ag, o_bg}, (i % 2 == 0) ? 2'b10 : 2'b01);
            ca += int'(o_ag);
            cb += int'(o_bg);
        end
        chk("alt_cnt_a", ca, 5);
        chk("alt_cnt_b", cb, 5);

        // Reset right after an A read grant abandons the return.
        idle_all();
        a_req = 1'b1; a_we = 1'b0;
        step();
        a_req = 1'b0; ssr = 1'b1;
        step();
        ssr = 1'b0; a_req = 1'b1; b_req = 1'b1;
        step();
        chk("rst_mid_rv", o_av, 1'b0);
        chk("rst_mid_rd", o_rd, SRV);
        chk("rst_mid_tie", o_ag, 1'b1);
        idle_all();
        step();

`ifdef RAMB16_ARB2_LOCK_EN
        do_reset();
        a_req = 1'b1; a_lock = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_cap", {o_ag, o_bg}, (i < 4) ? 2'b10 : 2'b01);
        end
        do_reset();
        a_req = 1'b1; a_lock = 1'b1; b_req = 1'b1;
        step();
        step();
        chk("lock_2nd", o_ag, 1'b1);
        a_req = 1'b0; a_lock = 1'b0;
        step();
        step();
        chk("lock_drop_b", o_bg, 1'b1);
        idle_all();
        step();
`endif

        for (int i = 0; i < 1500; i++) begin
            ssr    = ($urandom_range(0, 99) == 0);
            a_req  = 1'($urandom_range(0, 1));
            b_req  = 1'($urandom_range(0, 1));
            a_we   = 1'($urandom_range(0, 1));
            b_we   = 1'($urandom_range(0, 1));
            a_addr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            b_addr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            a_di   = $urandom;
            b_di   = $urandom;
            a_dip  = 4'($urandom);
            b_dip  = 4'($urandom);
`ifdef RAMB16_ARB2_LOCK_EN
            a_lock = 1'($urandom_range(0, 1));
            b_lock = 1'($urandom_range(0, 1));
`endif
            step();
        end
        ssr = 1'b0;
        idle_all();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
